// File: rtl/axi4lite_slave_regs.sv
// -----------------------------------------------------------------------------
// axi4lite_slave_regs
//
// AXI4-Lite responder holding NUM_REGS 32-bit registers. reg0 is exported on
// ctrl_out, and its bit 0 drives led. The write channel (AW/W/B) and the read
// channel (AR/R) each run their own small FSM, allow one outstanding
// transaction, and never block each other.
//
// Write FSM:
//   state      | meaning
//   W_IDLE     | accepting AW and W, either order or together
//   W_HAVE_AW  | address held, waiting for write data
//   W_HAVE_W   | data/strobes held, waiting for write address
//   W_RESP     | write committed, B response presented until bready
//
// Read FSM:
//   state      | meaning
//   R_IDLE     | accepting AR
//   R_DATA     | R response presented until rready
//
// Ports:
//   sysclk, rst              clock (rising edge), synchronous active-high reset
//   s_aw*, s_w*, s_b*        AXI4-Lite write address / data / response
//   s_ar*, s_r*              AXI4-Lite read address / data
//   ctrl_out                 current value of reg0
//   led                      reg0[0]
//
// Every ready/valid/response output comes straight from a flop. Readies are
// derived from the next FSM state so they are already correct on the cycle
// after any handshake.
// -----------------------------------------------------------------------------
module axi4lite_slave_regs #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 4
) (
    input  logic                      sysclk,
    input  logic                      rst,

    input  logic [ADDR_WIDTH-1:0]     s_awaddr,
    input  logic                      s_awvalid,
    output logic                      s_awready,

    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,

    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,

    input  logic [ADDR_WIDTH-1:0]     s_araddr,
    input  logic                      s_arvalid,
    output logic                      s_arready,

    output logic [DATA_WIDTH-1:0]     s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,

    output logic [DATA_WIDTH-1:0]     ctrl_out,
    output logic                      led
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = ADDR_WIDTH - 2;

    localparam logic [1:0] W_IDLE    = 2'd0;
    localparam logic [1:0] W_HAVE_AW = 2'd1;
    localparam logic [1:0] W_HAVE_W  = 2'd2;
    localparam logic [1:0] W_RESP    = 2'd3;

    localparam logic R_IDLE = 1'b0;
    localparam logic R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic [1:0]            w_state_q, w_state_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;

    logic                  r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    // Byte-offset bits never select anything; unaligned accesses hit the
    // containing word.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic                  aw_hs, w_hs, b_hs;
    logic                  commit;
    logic [IDX_W-1:0]      commit_idx;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [STRB_W-1:0]     commit_strb;
    logic                  commit_ok;

    assign aw_hs = s_awvalid & awready_q;
    assign w_hs  = s_wvalid  & wready_q;
    assign b_hs  = bvalid_q  & s_bready;

    // Whichever half arrived earlier comes from the holding flops; the half
    // arriving on the commit edge comes straight from the bus.
    assign commit_idx  = (w_state_q == W_HAVE_AW) ? aw_idx_q : s_awaddr[ADDR_WIDTH-1:2];
    assign commit_data = (w_state_q == W_HAVE_W)  ? wdata_q  : s_wdata;
    assign commit_strb = (w_state_q == W_HAVE_W)  ? wstrb_q  : s_wstrb;
    assign commit_ok   = (int'(commit_idx) < NUM_REGS);

    always_comb begin
        w_state_d = w_state_q;
        commit    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    w_state_d = W_RESP;
                    commit    = 1'b1;
                end else if (aw_hs) begin
                    w_state_d = W_HAVE_AW;
                end else if (w_hs) begin
                    w_state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_hs) begin
                    w_state_d = W_RESP;
                    commit    = 1'b1;
                end
            end
            W_HAVE_W: begin
                if (aw_hs) begin
                    w_state_d = W_RESP;
                    commit    = 1'b1;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        aw_idx_d  = aw_hs ? s_awaddr[ADDR_WIDTH-1:2] : aw_idx_q;
        wdata_d   = w_hs  ? s_wdata : wdata_q;
        wstrb_d   = w_hs  ? s_wstrb : wstrb_q;

        awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_W);
        wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_AW);
        bvalid_d  = (w_state_d == W_RESP);
        bresp_d   = bresp_q;
        if (commit) begin
            bresp_d = commit_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Byte-lane merge into the addressed register; out-of-range writes
    // leave every register untouched.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        if (commit && commit_ok) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (int'(commit_idx) == r) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (commit_strb[b]) begin
                            regs_d[r][8*b +: 8] = commit_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic                  ar_hs, r_hs;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] rd_word;

    assign ar_hs  = s_arvalid & arready_q;
    assign r_hs   = rvalid_q  & s_rready;
    assign rd_idx = s_araddr[ADDR_WIDTH-1:2];
    assign rd_ok  = (int'(rd_idx) < NUM_REGS);

    // Reads sample regs_q, so a read handshaking on the commit edge of a
    // write to the same register returns the pre-write value.
    always_comb begin
        rd_word = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (int'(rd_idx) == r) begin
                rd_word = regs_q[r];
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    rdata_d   = rd_ok ? rd_word : '0;
                    rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            w_state_q <= W_IDLE;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            w_state_q <= w_state_d;
            aw_idx_q  <= aw_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign ctrl_out  = regs_q[0];
    assign led       = regs_q[0][0];

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
module tb_axi4lite_slave_regs;

    logic        sysclk = 1'b0;
    logic        rst;
    logic [4:0]  s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [4:0]  s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic [31:0] ctrl_out;
    logic        led;

    int checks = 0;
    int errors = 0;

    always #5 sysclk = ~sysclk;

    axi4lite_slave_regs #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32),
        .NUM_REGS   (4)
    ) dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .ctrl_out  (ctrl_out),
        .led       (led)
    );

    typedef struct {
        bit          is_write;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for handshake", nm);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " awready"}, 32'(s_awready), 32'd0);
        check({nm, " wready"},  32'(s_wready),  32'd0);
        check({nm, " arready"}, 32'(s_arready), 32'd0);
        check({nm, " bvalid"},  32'(s_bvalid),  32'd0);
        check({nm, " rvalid"},  32'(s_rvalid),  32'd0);
        check({nm, " bresp"},   32'(s_bresp),   32'd0);
        check({nm, " rresp"},   32'(s_rresp),   32'd0);
        check({nm, " rdata"},   s_rdata,        32'd0);
        check({nm, " ctrl_out"}, ctrl_out,      32'd0);
        check({nm, " led"},     32'(led),       32'd0);
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_now, w_now;
        int n = 0;
        s_awaddr  = a;
        s_wdata   = d;
        s_wstrb   = s;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_now = s_awvalid && s_awready;
            w_now  = s_wvalid && s_wready;
            tick();
            if (aw_now) begin aw_done = 1; s_awvalid = 1'b0; end
            if (w_now)  begin w_done  = 1; s_wvalid  = 1'b0; end
            n++;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        if (!(aw_done && w_done)) timeout("write addr/data");
        n = 0;
        while (!s_bvalid && n < 20) begin
            tick();
            n++;
        end
        resp = 2'bxx;
        if (!s_bvalid) begin
            timeout("write response");
        end else begin
            resp = s_bresp;
            s_bready = 1'b1;
            tick();
            s_bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit ar_done = 0;
        bit ar_now;
        int n = 0;
        s_araddr  = a;
        s_arvalid = 1'b1;
        while (!ar_done && n < 20) begin
            ar_now = s_arvalid && s_arready;
            tick();
            if (ar_now) begin ar_done = 1; s_arvalid = 1'b0; end
            n++;
        end
        s_arvalid = 1'b0;
        if (!ar_done) timeout("read addr");
        n = 0;
        while (!s_rvalid && n < 20) begin
            tick();
            n++;
        end
        d = 'x;
        resp = 2'bxx;
        if (!s_rvalid) begin
            timeout("read data");
        end else begin
            d    = s_rdata;
            resp = s_rresp;
            s_rready = 1'b1;
            tick();
            s_rready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;
        logic [1:0]  br;

        vecs[0]  = '{1, 5'h08, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1, 5'h08, 32'h0000_1200, 4'h2, 2'b00, 32'h0};
        vecs[2]  = '{0, 5'h08, 32'h0,         4'h0, 2'b00, 32'hFFFF_12FF};
        vecs[3]  = '{1, 5'h0C, 32'h1234_5678, 4'h9, 2'b00, 32'h0};
        vecs[4]  = '{0, 5'h0E, 32'h0,         4'h0, 2'b00, 32'h1200_0078};
        vecs[5]  = '{1, 5'h10, 32'hDEAD_BEEF, 4'hF, 2'b10, 32'h0};
        vecs[6]  = '{0, 5'h1C, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[7]  = '{0, 5'h00, 32'h0,         4'h0, 2'b00, 32'h0000_0001};
        vecs[8]  = '{0, 5'h04, 32'h0,         4'h0, 2'b00, 32'hA5A5_A5A5};
        vecs[9]  = '{0, 5'h08, 32'h0,         4'h0, 2'b00, 32'hFFFF_12FF};
        vecs[10] = '{0, 5'h0C, 32'h0,         4'h0, 2'b00, 32'h1200_0078};
        vecs[11] = '{1, 5'h01, 32'h0000_0300, 4'h2, 2'b00, 32'h0};
        vecs[12] = '{0, 5'h03, 32'h0,         4'h0, 2'b00, 32'h0000_0301};

        rst = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0;
        s_wdata = '0;  s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0;
        s_araddr = '0; s_arvalid = 1'b0;
        s_rready = 1'b0;

        // Reset state
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check("post-reset awready", 32'(s_awready), 32'd1);
        check("post-reset wready",  32'(s_wready),  32'd1);
        check("post-reset arready", 32'(s_arready), 32'd1);

        // AW and W together to reg0
        s_awaddr = 5'h00; s_wdata = 32'h1; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        check("A bvalid",   32'(s_bvalid),  32'd1);
        check("A bresp",    32'(s_bresp),   32'd0);
        check("A led",      32'(led),       32'd1);
        check("A ctrl_out", ctrl_out,       32'h1);
        check("A awready",  32'(s_awready), 32'd0);
        check("A wready",   32'(s_wready),  32'd0);
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        check("A bvalid drop",   32'(s_bvalid),  32'd0);
        check("A awready back",  32'(s_awready), 32'd1);

        // W three cycles ahead of AW
        s_wdata = 32'hA5A5_A5A5; s_wstrb = 4'hF; s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        check("B wready after W",  32'(s_wready),  32'd0);
        check("B awready after W", 32'(s_awready), 32'd1);
        tick();
        tick();
        check("B no early bvalid", 32'(s_bvalid),  32'd0);
        check("B awready held",    32'(s_awready), 32'd1);
        s_awaddr = 5'h04; s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        check("B bvalid", 32'(s_bvalid), 32'd1);
        check("B bresp",  32'(s_bresp),  32'd0);
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        axi_read(5'h04, rd, rr);
        check("B read data", rd,      32'hA5A5_A5A5);
        check("B read resp", 32'(rr), 32'd0);

        // Table-driven accesses
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_write) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, br);
                check($sformatf("vec%0d bresp", i), 32'(br), 32'(vecs[i].exp_resp));
            end else begin
                axi_read(vecs[i].addr, rd, rr);
                check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
                check($sformatf("vec%0d rresp", i), 32'(rr), 32'(vecs[i].exp_resp));
            end
        end
        check("table ctrl_out", ctrl_out, 32'h0000_0301);
        check("table led",      32'(led), 32'd1);

        // Stalled responses; read of reg3 on the same edge as its write
        s_awaddr = 5'h0C; s_wdata = 32'hCAFE_0000; s_wstrb = 4'hF;
        s_araddr = 5'h0C;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("C%0d bvalid", c),  32'(s_bvalid),  32'd1);
            check($sformatf("C%0d bresp", c),   32'(s_bresp),   32'd0);
            check($sformatf("C%0d rvalid", c),  32'(s_rvalid),  32'd1);
            check($sformatf("C%0d rdata", c),   s_rdata,        32'h1200_0078);
            check($sformatf("C%0d rresp", c),   32'(s_rresp),   32'd0);
            check($sformatf("C%0d awready", c), 32'(s_awready), 32'd0);
            check($sformatf("C%0d wready", c),  32'(s_wready),  32'd0);
            check($sformatf("C%0d arready", c), 32'(s_arready), 32'd0);
            tick();
        end
        s_bready = 1'b1; s_rready = 1'b1;
        tick();
        s_bready = 1'b0; s_rready = 1'b0;
        check("C bvalid drop",  32'(s_bvalid),  32'd0);
        check("C rvalid drop",  32'(s_rvalid),  32'd0);
        check("C awready back", 32'(s_awready), 32'd1);
        check("C arready back", 32'(s_arready), 32'd1);
        axi_read(5'h0C, rd, rr);
        check("C new value", rd, 32'hCAFE_0000);

        // Reset while holding an address only
        s_awaddr = 5'h00; s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        check("D in HAVE_AW awready", 32'(s_awready), 32'd0);
        check("D in HAVE_AW wready",  32'(s_wready),  32'd1);
        rst = 1'b1;
        tick();
        check_all_zero("D reset");
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("D%0d no bvalid", c), 32'(s_bvalid), 32'd0);
        end
        for (int r = 0; r < 4; r++) begin
            axi_read(5'(r * 4), rd, rr);
            check($sformatf("D reg%0d cleared", r), rd, 32'h0);
        end
        // A lone W must wait for a fresh AW; the pre-reset address is gone.
        s_wdata = 32'h0000_0055; s_wstrb = 4'hF; s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        tick();
        check("D W-only no bvalid", 32'(s_bvalid), 32'd0);
        check("D W-only wready",    32'(s_wready), 32'd0);
        s_awaddr = 5'h04; s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        check("D fresh bvalid", 32'(s_bvalid), 32'd1);
        check("D fresh bresp",  32'(s_bresp),  32'd0);
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        axi_read(5'h04, rd, rr);
        check("D fresh readback", rd, 32'h0000_0055);
        check("D ctrl_out still 0", ctrl_out, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
